// File: rtl/memory_access_responder.sv
// -----------------------------------------------------------------------------
// memory_access_responder
//   Byte-addressed memory responder for the address side of the CPU datapath.
//   One request moves 1, 2 or 4 bytes, one byte per clock, in little-endian
//   order. Completion is flagged by a single-cycle o_done pulse. A read returns
//   a zero-extended word on o_data_out.
//
// Parameters
//   ADDR_BITS   index width of the internal byte array (DEPTH = 2**ADDR_BITS)
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_req       request strobe, sampled only while idle
//   i_write     1 = write, 0 = read (captured with i_req)
//   i_size      00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   i_addr      start byte address (captured with i_req)
//   i_data_in   write data, byte i = i_data_in[8i+7:8i] (captured with i_req)
//   o_data_out  read result, valid while o_done = 1 and held until the next
//               read is accepted
//   o_busy      high from the cycle after acceptance until o_done drops
//   o_done      one-cycle completion pulse
// -----------------------------------------------------------------------------
module memory_access_responder #(
  parameter int ADDR_BITS = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [1:0]  i_size,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_busy,
  output logic        o_done
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                 r_write;
  logic [1:0]           r_size;
  logic [15:0]          r_addr;
  logic [31:0]          r_data;
  logic [1:0]           r_count;
  logic [31:0]          r_data_out;
  logic [7:0]           r_mem [DEPTH];

  logic [1:0]           w_last_idx;
  logic                 w_last;
  logic                 w_accept;
  logic [ADDR_BITS-1:0] w_index;
  logic [7:0]           w_rd_byte;
  logic [7:0]           w_wr_byte;

  assign w_accept = (r_state == IDLE) && i_req;

  // Size code 11 is treated as a 4-byte access, same as 10.
  always_comb begin
    w_last_idx = 2'd3;
    case (r_size)
      2'b00:   w_last_idx = 2'd0;
      2'b01:   w_last_idx = 2'd1;
      default: w_last_idx = 2'd3;
    endcase
  end

  assign w_last = (r_count == w_last_idx);

  // Only the low ADDR_BITS bits of the 16-bit sum select the byte, so the
  // upper address bits are ignored and accesses wrap from DEPTH-1 back to 0.
  assign w_index   = ADDR_BITS'(r_addr + 16'(r_count));
  assign w_rd_byte = r_mem[w_index];
  assign w_wr_byte = r_data[{r_count, 3'b000} +: 8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_next_state = XFER;
        end
      end
      XFER: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture, byte counter and read assembly. o_data_out is cleared
  // when a read is accepted so that bytes beyond the transfer size stay 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 16'd0;
      r_data     <= 32'd0;
      r_count    <= 2'd0;
      r_data_out <= 32'd0;
    end else if (w_accept) begin
      r_write <= i_write;
      r_size  <= i_size;
      r_addr  <= i_addr;
      r_data  <= i_data_in;
      r_count <= 2'd0;
      if (!i_write) begin
        r_data_out <= 32'd0;
      end
    end else if (r_state == XFER) begin
      if (!w_last) begin
        r_count <= r_count + 2'd1;
      end
      if (!r_write) begin
        r_data_out[{r_count, 3'b000} +: 8] <= w_rd_byte;
      end
    end
  end

  // The array itself is not reset. While reset is held the FSM sits in IDLE,
  // so an aborted write stops writing at once.
  always_ff @(posedge i_clk) begin
    if ((r_state == XFER) && r_write) begin
      r_mem[w_index] <= w_wr_byte;
    end
  end

  assign o_data_out = r_data_out;

endmodule

// File: tb/tb_memory_access_responder.sv
// -----------------------------------------------------------------------------
// tb_memory_access_responder
//   Directed bench for memory_access_responder. A transaction-level model tracks
//   the byte memory, the expected busy/done timing and the expected read word.
//   A negedge compare process checks the DUT against it on every cycle. Literal
//   expectations on the directed scenarios pin the model itself.
// -----------------------------------------------------------------------------
module tb_memory_access_responder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [15:0] addr  = 16'd0;
  logic [31:0] din   = 32'd0;
  logic [31:0] dout;
  logic        busy;
  logic        done;

  int checks  = 0;
  int errors  = 0;
  int busyCnt = 0;

  always #5 clk = ~clk;

  memory_access_responder #(.ADDR_BITS(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_write    (wr),
    .i_size     (size),
    .i_addr     (addr),
    .i_data_in  (din),
    .o_data_out (dout),
    .o_busy     (busy),
    .o_done     (done)
  );

  // Transaction model: mAge counts edges since acceptance. Edges at ages
  // 0..N-1 move byte mAge; the cycle after age N is the Done cycle.
  logic        mActive = 1'b0;
  int          mAge    = 0;
  int          mN      = 1;
  logic        mWrite  = 1'b0;
  logic [15:0] mAddr   = 16'd0;
  logic [31:0] mData   = 32'd0;
  logic [31:0] expData = 32'd0;
  logic [7:0]  modelMem [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive <= 1'b0;
      mAge    <= 0;
      expData <= 32'd0;
    end else if (!mActive) begin
      if (req) begin
        mActive <= 1'b1;
        mAge    <= 0;
        mWrite  <= wr;
        mN      <= (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
        mAddr   <= addr;
        mData   <= din;
        if (!wr) expData <= 32'd0;
      end
    end else begin
      if (mAge < mN) begin
        if (mWrite)
          modelMem[(int'(mAddr) + mAge) % 256] <= mData[8*mAge +: 8];
        else
          expData[8*mAge +: 8] <= modelMem[(int'(mAddr) + mAge) % 256];
      end else begin
        mActive <= 1'b0;
      end
      mAge <= mAge + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("busy", {31'd0, busy}, {31'd0, mActive});
    checkOutput("done", {31'd0, done}, {31'd0, (mActive && (mAge == mN))});
    checkOutput("data_out", dout, expData);
  end

  // Runs one transaction. When pokeAt > 0, a conflicting write request is
  // driven for one cycle at that cycle after acceptance; the DUT must ignore it.
  task automatic applyStimulus(input logic w, input logic [1:0] sz,
                               input logic [15:0] a, input logic [31:0] d,
                               input int pokeAt, output int lat,
                               output logic [31:0] result);
    bit seen;
    seen    = 1'b0;
    lat     = 0;
    result  = 32'd0;
    busyCnt = 0;
    @(posedge clk); #1;
    req = 1'b1; wr = w; size = sz; addr = a; din = d;
    @(posedge clk); #1;
    req = 1'b0; din = ~d;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (busy) busyCnt++;
      if (pokeAt == lat) begin
        req = 1'b1; wr = 1'b1; addr = a + 16'd1; din = 32'hDEADBEEF;
      end else begin
        req = 1'b0;
      end
      if (done) begin
        seen   = 1'b1;
        result = dout;
      end
    end
    req = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: no done within 12 cycles at %0t", $time);
    end
    @(posedge clk);
  endtask

  initial begin
    int          lat;
    logic [31:0] res;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset data_out", dout, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // T1: 4-byte write, latency and busy length
    applyStimulus(1'b1, 2'b10, 16'h0010, 32'h11223344, 0, lat, res);
    checkOutput("T1 latency", lat, 32'd5);
    checkOutput("T1 busy cycles", busyCnt, 32'd5);

    // T2: read back, then hold
    applyStimulus(1'b0, 2'b10, 16'h0010, 32'h0, 0, lat, res);
    checkOutput("T2 read", res, 32'h11223344);
    repeat (3) @(negedge clk);
    checkOutput("T2 hold", dout, 32'h11223344);

    // T3: narrow reads zero-extend
    applyStimulus(1'b0, 2'b00, 16'h0012, 32'h0, 0, lat, res);
    checkOutput("T3 byte read", res, 32'h00000022);
    checkOutput("T3 byte latency", lat, 32'd2);
    applyStimulus(1'b0, 2'b01, 16'h0011, 32'h0, 0, lat, res);
    checkOutput("T3 half read", res, 32'h00002233);

    // T4: wrap at the top of the array, upper address bits ignored
    applyStimulus(1'b1, 2'b10, 16'h00FE, 32'hAABBCCDD, 0, lat, res);
    applyStimulus(1'b0, 2'b10, 16'h00FE, 32'h0, 0, lat, res);
    checkOutput("T4 wrap read", res, 32'hAABBCCDD);
    applyStimulus(1'b0, 2'b01, 16'h0000, 32'h0, 0, lat, res);
    checkOutput("T4 low half", res, 32'h0000AABB);
    applyStimulus(1'b1, 2'b10, 16'h00FE, 32'h00000000, 0, lat, res);
    applyStimulus(1'b1, 2'b10, 16'h12FE, 32'hAABBCCDD, 0, lat, res);
    applyStimulus(1'b0, 2'b10, 16'h34FE, 32'h0, 0, lat, res);
    checkOutput("T4 high addr read", res, 32'hAABBCCDD);

    // T5: requests while busy are ignored; size 11 acts as 4 bytes
    applyStimulus(1'b1, 2'b10, 16'h0030, 32'h0BADF00D, 1, lat, res);
    applyStimulus(1'b0, 2'b10, 16'h0030, 32'h0, 2, lat, res);
    checkOutput("T5 ignored req", res, 32'h0BADF00D);
    applyStimulus(1'b1, 2'b11, 16'h0050, 32'hCAFEBABE, 0, lat, res);
    applyStimulus(1'b0, 2'b11, 16'h0050, 32'h0, 0, lat, res);
    checkOutput("T5 size11 read", res, 32'hCAFEBABE);
    checkOutput("T5 size11 latency", lat, 32'd5);

    // T6: reset during a write after two bytes have landed
    applyStimulus(1'b1, 2'b10, 16'h0040, 32'h01020304, 0, lat, res);
    applyStimulus(1'b0, 2'b10, 16'h0030, 32'h0, 0, lat, res);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 16'h0040; din = 32'h55667788;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("T6 abort busy", {31'd0, busy}, 32'd0);
    checkOutput("T6 abort done", {31'd0, done}, 32'd0);
    checkOutput("T6 abort data_out", dout, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b10, 16'h0040, 32'h0, 0, lat, res);
    checkOutput("T6 partial write", res, 32'h01027788);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
